cdc_handshake_bus: RTL and testbench
====================================

# cdc_handshake_bus

Parametrised 4-phase req/ack clock-domain-crossing bus that moves one DATA_W-bit word at a time from the clk_a domain to the clk_b domain. Both sides use valid/ready interfaces with full backpressure, and the synchroniser depth is configurable. The block sits between any clk_a producer and clk_b consumer in the design and supersedes fixed-width, fixed-rate driver/receiver pairs.

## Interface
Parameters:
- DATA_W, default 8: payload width, legal range 1..64.
- SYNC_STAGES, default 2: flops per synchroniser chain, legal range 2..4.

Ports:
- clk_a, input, 1: source clock.
- clk_b, input, 1: destination clock.
- rst_n, input, 1: reset, asynchronous, active-low, shared by both domains. Deassertion is synchronised externally per domain.
- src_valid, input, 1: source word offered (clk_a).
- src_data, input, DATA_W: source word (clk_a).
- src_ready, output, 1: source accepts word this cycle (clk_a).
- dst_valid, output, 1: word available (clk_b).
- dst_data, output, DATA_W: delivered word (clk_b).
- dst_ready, input, 1: consumer accepts word (clk_b).
- src_count, output, 16: transfers completed, as seen from clk_a.
- dst_count, output, 16: words delivered, as seen from clk_b.

## Operation
- Source FSM (clk_a) has three states.
  - S_IDLE: src_ready=1. A src_valid&src_ready edge latches src_data into hold_q, sets req=1, and moves to S_REQ.
  - S_REQ: req=1, src_ready=0. When ack_sync becomes 1: req=0, go to S_DROP.
  - S_DROP: req=0, src_ready=0. When ack_sync becomes 0: src_count+1, go to S_IDLE.
- Destination FSM (clk_b) has three states.
  - D_IDLE: when req_sync becomes 1, capture hold_q into dst_data, set dst_valid=1, go to D_HOLD.
  - D_HOLD: dst_valid=1. A dst_valid&dst_ready edge sets dst_valid=0, ack=1, dst_count+1, and moves to D_ACK.
  - D_ACK: ack=1. When req_sync becomes 0: ack=0, go to D_IDLE.
- hold_q is written only in S_IDLE on acceptance. It is stable from req rising until the source returns to S_IDLE, so the destination captures a stable multi-bit value.
- req and ack are each registered outputs of their own domain. Each is synchronised into the other domain through SYNC_STAGES flops. No other signal crosses a domain.
- Counters are 16-bit and wrap 0xFFFF→0x0000.
- Backpressure: if dst_ready is held low, the destination stays in D_HOLD indefinitely. The source stays in S_REQ with src_ready=0, and no words are lost or duplicated.

## Timing
Reset values:
- All of the following are 0 during reset: src_ready, req, ack, dst_valid, dst_data, hold_q, src_count, dst_count, and all synchroniser flops.
- Both FSMs reset to IDLE.
- src_ready is 1 from the first clk_a edge after reset release.

Latency and throughput:
- Acceptance edge to dst_valid=1: SYNC_STAGES+1 clk_b edges after req is seen, plus up to one clk_b period of phase uncertainty.
- dst handshake to src_ready=1: 2×(SYNC_STAGES+1) clk_a edges, plus one clk_b round trip for ack/req fall.
- Minimum per-word period: 2×(SYNC_STAGES+1) cycles in each domain. One word is in flight at a time.

Boundary conditions:
- src_valid held with src_ready=0: no capture. The source may change src_data freely.
- dst_ready high while dst_valid is low: ignored.
- dst_ready already high when dst_valid rises: the handshake completes on the next clk_b edge. Minimum dst_valid pulse is 1 cycle.
- rst_n asserted mid-transfer: all state clears immediately, the in-flight word is discarded, and no partial word is delivered after reset.

## Structure
- Shared package cdc_pkg holds:
  - src_state_t with S_IDLE, S_REQ, S_DROP;
  - dst_state_t with D_IDLE, D_HOLD, D_ACK;
  - localparam CNT_W=16.
- Sub-module cdc_sync_bit (parameter STAGES): an async-reset flop chain. It is instantiated twice: req into clk_b and ack into clk_a.
- Source and destination logic live in the top module as two separately clocked always blocks.

## Test plan
- Single transfer, DATA_W=8, SYNC_STAGES=2, clk_a 10 ns, clk_b 17 ns: send 0xA5 with dst_ready=1 → dst_data=0xA5 with one dst_valid pulse; src_count=1 and dst_count=1.
- Stream 0x00..0xFF back-to-back with src_valid held high → all 256 words arrive in order with none missing or duplicated; both counters read 256 mod 65536.
- Backpressure: dst_ready=0 for 50 clk_b cycles after dst_valid → dst_data is held at 0x3C, src_ready stays 0, and the transfer completes once dst_ready=1.
- Clock ratio swap (clk_a 23 ns, clk_b 5 ns) and SYNC_STAGES=3 → same data integrity; latency stays within the formula in Timing.
- Reset asserted while the source is in S_REQ → all outputs 0 immediately. After release, the word 0x11 transfers cleanly and the aborted word never appears.
- Counter wrap: preload or run 65536 transfers → src_count and dst_count return to 0x0000.

Source files
------------

// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and constants for the req/ack clock-domain-crossing bus
package cdc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } src_state_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_HOLD = 2'd1,
        D_ACK  = 2'd2
    } dst_state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/cdc_sync_bit.sv
// rtl/cdc_sync_bit.sv - single-bit multi-flop synchroniser with asynchronous reset
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the foreign-domain level through STAGES flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_bus.sv
// rtl/cdc_handshake_bus.sv - 4-phase req/ack word transfer from clk_a to clk_b with valid/ready on both sides
module cdc_handshake_bus
    import cdc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_a,
    input  logic              clk_b,
    input  logic              rst_n,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              dst_valid,
    output logic [DATA_W-1:0] dst_data,
    input  logic              dst_ready,
    output logic [CNT_W-1:0]  src_count,
    output logic [CNT_W-1:0]  dst_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // clk_a domain state
    src_state_t          src_state_q, src_state_d;
    logic                req_q, req_d;
    logic                src_ready_q, src_ready_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    src_count_q, src_count_d;
    logic                ack_sync;

    // clk_b domain state
    dst_state_t          dst_state_q, dst_state_d;
    logic                ack_q, ack_d;
    logic                dst_valid_q, dst_valid_d;
    logic [DATA_W-1:0]   dst_data_q, dst_data_d;
    logic [CNT_W-1:0]    dst_count_q, dst_count_d;
    logic                req_sync;

    // req crosses into clk_b, ack crosses back into clk_a; nothing else is synchronised
    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk_b),
        .rst_n (rst_n),
        .d     (req_q),
        .q     (req_sync)
    );

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk_a),
        .rst_n (rst_n),
        .d     (ack_q),
        .q     (ack_sync)
    );

    // Source registers; src_ready is registered so it stays low throughout reset
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            src_state_q <= S_IDLE;
            req_q       <= 1'b0;
            src_ready_q <= 1'b0;
            hold_q      <= '0;
            src_count_q <= '0;
        end else begin
            src_state_q <= src_state_d;
            req_q       <= req_d;
            src_ready_q <= src_ready_d;
            hold_q      <= hold_d;
            src_count_q <= src_count_d;
        end
    end

    // Source next state: accept, raise req, wait ack high, drop req, wait ack low
    always_comb begin
        src_state_d = src_state_q;
        req_d       = req_q;
        hold_d      = hold_q;
        src_count_d = src_count_q;
        case (src_state_q)
            S_IDLE: begin
                if (src_valid && src_ready_q) begin
                    hold_d      = src_data;
                    req_d       = 1'b1;
                    src_state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_sync) begin
                    req_d       = 1'b0;
                    src_state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (!ack_sync) begin
                    src_count_d = src_count_q + CNT_ONE;
                    src_state_d = S_IDLE;
                end
            end
            default: begin
                req_d       = 1'b0;
                src_state_d = S_IDLE;
            end
        endcase
        src_ready_d = (src_state_d == S_IDLE);
    end

    // Destination registers
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            dst_state_q <= D_IDLE;
            ack_q       <= 1'b0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
            dst_count_q <= '0;
        end else begin
            dst_state_q <= dst_state_d;
            ack_q       <= ack_d;
            dst_valid_q <= dst_valid_d;
            dst_data_q  <= dst_data_d;
            dst_count_q <= dst_count_d;
        end
    end

    // Destination next state: capture the held word on req, present it, ack once consumed
    always_comb begin
        dst_state_d = dst_state_q;
        ack_d       = ack_q;
        dst_valid_d = dst_valid_q;
        dst_data_d  = dst_data_q;
        dst_count_d = dst_count_q;
        case (dst_state_q)
            D_IDLE: begin
                if (req_sync) begin
                    dst_data_d  = hold_q;
                    dst_valid_d = 1'b1;
                    dst_state_d = D_HOLD;
                end
            end
            D_HOLD: begin
                if (dst_valid_q && dst_ready) begin
                    dst_valid_d = 1'b0;
                    ack_d       = 1'b1;
                    dst_count_d = dst_count_q + CNT_ONE;
                    dst_state_d = D_ACK;
                end
            end
            D_ACK: begin
                if (!req_sync) begin
                    ack_d       = 1'b0;
                    dst_state_d = D_IDLE;
                end
            end
            default: begin
                ack_d       = 1'b0;
                dst_valid_d = 1'b0;
                dst_state_d = D_IDLE;
            end
        endcase
    end

    assign src_ready = src_ready_q;
    assign src_count = src_count_q;
    assign dst_valid = dst_valid_q;
    assign dst_data  = dst_data_q;
    assign dst_count = dst_count_q;

endmodule

// File: tb/tb_cdc_handshake_bus.sv
// tb/tb_cdc_handshake_bus.sv - directed self-checking bench for cdc_handshake_bus
module tb_cdc_handshake_bus;

    logic clk_a0 = 1'b0;
    logic clk_b0 = 1'b0;
    logic clk_a1 = 1'b0;
    logic clk_b1 = 1'b0;
    logic rst_n  = 1'b1;

    always #50  clk_a0 = ~clk_a0;
    always #85  clk_b0 = ~clk_b0;
    always #115 clk_a1 = ~clk_a1;
    always #25  clk_b1 = ~clk_b1;

    logic        src_valid0 = 1'b0;
    logic [7:0]  src_data0  = 8'h00;
    logic        src_ready0;
    logic        dst_valid0;
    logic [7:0]  dst_data0;
    logic        dst_ready0 = 1'b0;
    logic [15:0] src_count0;
    logic [15:0] dst_count0;

    logic        src_valid1 = 1'b0;
    logic [7:0]  src_data1  = 8'h00;
    logic        src_ready1;
    logic        dst_valid1;
    logic [7:0]  dst_data1;
    logic        dst_ready1 = 1'b0;
    logic [15:0] src_count1;
    logic [15:0] dst_count1;

    cdc_handshake_bus #(.DATA_W(8), .SYNC_STAGES(2)) dut0 (
        .clk_a     (clk_a0),
        .clk_b     (clk_b0),
        .rst_n     (rst_n),
        .src_valid (src_valid0),
        .src_data  (src_data0),
        .src_ready (src_ready0),
        .dst_valid (dst_valid0),
        .dst_data  (dst_data0),
        .dst_ready (dst_ready0),
        .src_count (src_count0),
        .dst_count (dst_count0)
    );

    cdc_handshake_bus #(.DATA_W(8), .SYNC_STAGES(3)) dut1 (
        .clk_a     (clk_a1),
        .clk_b     (clk_b1),
        .rst_n     (rst_n),
        .src_valid (src_valid1),
        .src_data  (src_data1),
        .src_ready (src_ready1),
        .dst_valid (dst_valid1),
        .dst_data  (dst_data1),
        .dst_ready (dst_ready1),
        .src_count (src_count1),
        .dst_count (dst_count1)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] got0[$];
    logic [7:0] got1[$];
    logic       pv0 = 1'b0;
    logic       pv1 = 1'b0;

    // Record each word once, on the rising edge of dst_valid
    always @(negedge clk_b0) begin
        if (dst_valid0 && !pv0) got0.push_back(dst_data0);
        pv0 = dst_valid0;
    end

    always @(negedge clk_b1) begin
        if (dst_valid1 && !pv1) got1.push_back(dst_data1);
        pv1 = dst_valid1;
    end

    task automatic send0(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        @(negedge clk_a0);
        src_valid0 = 1'b1;
        src_data0  = d;
        for (int i = 0; i < 2000; i++) begin
            if (src_ready0 === 1'b1) begin
                @(negedge clk_a0);
                ok = 1'b1;
                break;
            end
            @(negedge clk_a0);
        end
    endtask

    task automatic send1(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        @(negedge clk_a1);
        src_valid1 = 1'b1;
        src_data1  = d;
        for (int i = 0; i < 2000; i++) begin
            if (src_ready1 === 1'b1) begin
                @(negedge clk_a1);
                ok = 1'b1;
                break;
            end
            @(negedge clk_a1);
        end
    endtask

    task automatic wait_got0(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (got0.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk_b0);
        end
    endtask

    task automatic wait_got1(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (got1.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk_b1);
        end
    endtask

    task automatic wait_idle0(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_a0);
            if (src_ready0 === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_a1);
            if (src_ready1 === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        dst_ready0 = 1'b1;
        dst_ready1 = 1'b1;
        #400;
        checks++; if (src_ready0 !== 1'b0) begin failures++; $display("FAIL reset_src_ready0 got=%b exp=0", src_ready0); end
        checks++; if (dst_valid0 !== 1'b0) begin failures++; $display("FAIL reset_dst_valid0 got=%b exp=0", dst_valid0); end
        checks++; if (dst_data0 !== 8'h00) begin failures++; $display("FAIL reset_dst_data0 got=%h exp=00", dst_data0); end
        checks++; if (src_count0 !== 16'h0000) begin failures++; $display("FAIL reset_src_count0 got=%h exp=0000", src_count0); end
        checks++; if (dst_count0 !== 16'h0000) begin failures++; $display("FAIL reset_dst_count0 got=%h exp=0000", dst_count0); end
        checks++; if (src_ready1 !== 1'b0) begin failures++; $display("FAIL reset_src_ready1 got=%b exp=0", src_ready1); end
        checks++; if (dst_valid1 !== 1'b0) begin failures++; $display("FAIL reset_dst_valid1 got=%b exp=0", dst_valid1); end
        #613;
        rst_n = 1'b1;
        @(posedge clk_a0);
        #1;
        checks++; if (src_ready0 !== 1'b1) begin failures++; $display("FAIL post_reset_src_ready0 got=%b exp=1", src_ready0); end
        @(posedge clk_a1);
        #1;
        checks++; if (src_ready1 !== 1'b1) begin failures++; $display("FAIL post_reset_src_ready1 got=%b exp=1", src_ready1); end
    endtask

    task automatic test_single();
        bit ok;
        got0.delete();
        send0(8'hA5, ok);
        src_valid0 = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL single_accept got=timeout exp=accepted"); end
        wait_got0(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_deliver got=timeout exp=delivered"); end
        wait_idle0(ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_idle got=timeout exp=src_ready"); end
        repeat (4) @(negedge clk_b0);
        checks++; if (got0.size() != 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", got0.size()); end
        checks++; if (got0.size() > 0 && got0[0] !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", got0[0]); end
        checks++; if (dst_valid0 !== 1'b0) begin failures++; $display("FAIL single_valid_low got=%b exp=0", dst_valid0); end
        checks++; if (src_count0 !== 16'd1) begin failures++; $display("FAIL single_src_count got=%0d exp=1", src_count0); end
        checks++; if (dst_count0 !== 16'd1) begin failures++; $display("FAIL single_dst_count got=%0d exp=1", dst_count0); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad_d;
        int bad_r;
        @(negedge clk_b0);
        dst_ready0 = 1'b0;
        got0.delete();
        send0(8'h3C, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_accept got=timeout exp=accepted"); end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_b0);
            if (dst_valid0 === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL bp_valid got=timeout exp=dst_valid"); end
        bad_d = 0;
        bad_r = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_b0);
            if (dst_valid0 !== 1'b1 || dst_data0 !== 8'h3C) bad_d++;
            if (src_ready0 !== 1'b0) bad_r++;
            #7 src_data0 = 8'($urandom);
        end
        checks++; if (bad_d != 0) begin failures++; $display("FAIL bp_hold_data got=%0d_bad_cycles exp=0", bad_d); end
        checks++; if (bad_r != 0) begin failures++; $display("FAIL bp_src_ready got=%0d_bad_cycles exp=0", bad_r); end
        checks++; if (dst_count0 !== 16'd1) begin failures++; $display("FAIL bp_dst_count_stall got=%0d exp=1", dst_count0); end
        checks++; if (src_count0 !== 16'd1) begin failures++; $display("FAIL bp_src_count_stall got=%0d exp=1", src_count0); end
        src_valid0 = 1'b0;
        @(negedge clk_b0);
        dst_ready0 = 1'b1;
        wait_idle0(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_idle got=timeout exp=src_ready"); end
        repeat (4) @(negedge clk_b0);
        checks++; if (got0.size() != 1) begin failures++; $display("FAIL bp_words got=%0d exp=1", got0.size()); end
        checks++; if (got0.size() > 0 && got0[0] !== 8'h3C) begin failures++; $display("FAIL bp_data got=%h exp=3c", got0[0]); end
        checks++; if (src_count0 !== 16'd2) begin failures++; $display("FAIL bp_src_count got=%0d exp=2", src_count0); end
        checks++; if (dst_count0 !== 16'd2) begin failures++; $display("FAIL bp_dst_count got=%0d exp=2", dst_count0); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit all_ok;
        int bad;
        got0.delete();
        all_ok = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send0(8'(i), ok);
            if (!ok) begin all_ok = 1'b0; break; end
        end
        src_valid0 = 1'b0;
        checks++; if (!all_ok) begin failures++; $display("FAIL stream_accept got=timeout exp=all_accepted"); end
        wait_got0(256, ok);
        wait_idle0(ok);
        repeat (4) @(negedge clk_b0);
        checks++; if (got0.size() != 256) begin failures++; $display("FAIL stream_count got=%0d exp=256", got0.size()); end
        bad = 0;
        for (int i = 0; i < got0.size() && i < 256; i++) begin
            if (got0[i] !== 8'(i)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL stream_order got=%0d_wrong exp=0", bad); end
        checks++; if (src_count0 !== 16'd258) begin failures++; $display("FAIL stream_src_count got=%0d exp=258", src_count0); end
        checks++; if (dst_count0 !== 16'd258) begin failures++; $display("FAIL stream_dst_count got=%0d exp=258", dst_count0); end
    endtask

    task automatic test_ratio_swap();
        bit ok;
        bit all_ok;
        int bad;
        int lat;
        got1.delete();
        all_ok = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            send1(8'(i * 37 + 5), ok);
            if (!ok) begin all_ok = 1'b0; break; end
            if (i == 0) begin
                for (int k = 0; k < 50; k++) begin
                    if (dst_valid1 === 1'b1) break;
                    @(negedge clk_b1);
                    lat++;
                end
            end
        end
        src_valid1 = 1'b0;
        checks++; if (!all_ok) begin failures++; $display("FAIL swap_accept got=timeout exp=all_accepted"); end
        checks++; if (lat < 1 || lat > 5) begin failures++; $display("FAIL swap_latency got=%0d exp=1..5", lat); end
        wait_got1(20, ok);
        wait_idle1(ok);
        repeat (8) @(negedge clk_b1);
        checks++; if (got1.size() != 20) begin failures++; $display("FAIL swap_count got=%0d exp=20", got1.size()); end
        bad = 0;
        for (int i = 0; i < got1.size() && i < 20; i++) begin
            if (got1[i] !== 8'(i * 37 + 5)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL swap_order got=%0d_wrong exp=0", bad); end
        checks++; if (src_count1 !== 16'd20) begin failures++; $display("FAIL swap_src_count got=%0d exp=20", src_count1); end
        checks++; if (dst_count1 !== 16'd20) begin failures++; $display("FAIL swap_dst_count got=%0d exp=20", dst_count1); end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        got0.delete();
        dst_ready0 = 1'b1;
        send0(8'h77, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_accept got=timeout exp=accepted"); end
        #23 rst_n = 1'b0;
        #1;
        checks++; if (src_ready0 !== 1'b0) begin failures++; $display("FAIL mid_src_ready got=%b exp=0", src_ready0); end
        checks++; if (dst_valid0 !== 1'b0) begin failures++; $display("FAIL mid_dst_valid got=%b exp=0", dst_valid0); end
        checks++; if (dst_data0 !== 8'h00) begin failures++; $display("FAIL mid_dst_data got=%h exp=00", dst_data0); end
        checks++; if (src_count0 !== 16'h0000) begin failures++; $display("FAIL mid_src_count got=%h exp=0000", src_count0); end
        checks++; if (dst_count0 !== 16'h0000) begin failures++; $display("FAIL mid_dst_count got=%h exp=0000", dst_count0); end
        src_valid0 = 1'b0;
        #300;
        got0.delete();
        rst_n = 1'b1;
        send0(8'h11, ok);
        src_valid0 = 1'b0;
        wait_got0(1, ok);
        wait_idle0(ok);
        repeat (20) @(negedge clk_b0);
        checks++; if (got0.size() != 1) begin failures++; $display("FAIL mid_words got=%0d exp=1", got0.size()); end
        checks++; if (got0.size() > 0 && got0[0] !== 8'h11) begin failures++; $display("FAIL mid_data got=%h exp=11", got0[0]); end
        checks++; if (src_count0 !== 16'd1) begin failures++; $display("FAIL mid_src_count_after got=%0d exp=1", src_count0); end
        checks++; if (dst_count0 !== 16'd1) begin failures++; $display("FAIL mid_dst_count_after got=%0d exp=1", dst_count0); end
    endtask

    task automatic test_counter_wrap();
        bit ok;
        #3;
        force dut0.src_count_q = 16'hFFFF;
        force dut0.dst_count_q = 16'hFFFF;
        #1;
        release dut0.src_count_q;
        release dut0.dst_count_q;
        got0.delete();
        send0(8'h5A, ok);
        src_valid0 = 1'b0;
        wait_got0(1, ok);
        wait_idle0(ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_idle got=timeout exp=src_ready"); end
        checks++; if (got0.size() < 1 || got0[0] !== 8'h5A) begin failures++; $display("FAIL wrap_data got_words=%0d exp=5a", got0.size()); end
        checks++; if (src_count0 !== 16'h0000) begin failures++; $display("FAIL wrap_src_count got=%h exp=0000", src_count0); end
        checks++; if (dst_count0 !== 16'h0000) begin failures++; $display("FAIL wrap_dst_count got=%h exp=0000", dst_count0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_ratio_swap();
        test_reset_midflight();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
